// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline valid/allow-in sequencer.
`timescale 1ns/1ps
package pipe_pkg;
    localparam int unsigned STAGE_NUM = 5;
    localparam int unsigned STG_IF    = 0;
    localparam int unsigned STG_ID    = 1;
    localparam int unsigned STG_EXE   = 2;
    localparam int unsigned STG_MEM   = 3;
    localparam int unsigned STG_WB    = 4;
    localparam int unsigned REG_ZERO  = 0;
    localparam int unsigned DBG_W     = 32;
endpackage

// File: rtl/pipe_stage_vld.sv
// One stage valid/allow-in/go cell; valid clears on flush, otherwise loads the
// upstream go whenever this stage can accept.
`timescale 1ns/1ps
module pipe_stage_vld (
    input  logic clk,
    input  logic reset,
    input  logic prev_go,
    input  logic over,
    input  logic next_allow_in,
    input  logic flush,
    output logic valid,
    output logic allow_in,
    output logic go
);
    assign go       = valid & over & next_allow_in & ~flush;
    assign allow_in = ~valid | go;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (allow_in) begin
            valid <= prev_go;
        end
    end
endmodule

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline valid/allow-in/go sequencer with load-use interlock and
// WB flush. Optional performance counters under PIPE_CTRL_PERF_EN.
`timescale 1ns/1ps
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_en,
    input  logic              if_over,
    input  logic              id_over,
    input  logic              exe_over,
    input  logic              mem_over,
    input  logic [REG_AW-1:0] id_src1,
    input  logic [REG_AW-1:0] id_src2,
    input  logic              id_src1_used,
    input  logic              id_src2_used,
    input  logic [REG_AW-1:0] exe_dest,
    input  logic              exe_is_load,
    input  logic              wb_flush,
    output logic              if_valid,
    output logic              id_valid,
    output logic              exe_valid,
    output logic              mem_valid,
    output logic              wb_valid,
    output logic              id_allow_in,
    output logic              exe_allow_in,
    output logic              mem_allow_in,
    output logic              wb_allow_in,
    output logic              if_go,
    output logic              id_go,
    output logic              exe_go,
    output logic              mem_go,
    output logic              load_use_stall,
    output logic [DBG_W-1:0]  cpu_5_valid
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0]  perf_retired,
    output logic [CNT_W-1:0]  perf_stall
`endif
);
    logic                 flush;
    logic                 if_allow_in;
    logic                 id_over_eff;
    logic                 src1_hit;
    logic                 src2_hit;
    logic                 wb_allow_unused;
    logic                 wb_go_unused;
    logic [STAGE_NUM-1:0] stage_v;

    assign flush       = wb_valid & wb_flush;
    assign wb_allow_in = 1'b1;

    // Only an EXE load can create a hazard; later results are forwarded.
    assign src1_hit       = id_src1_used & (id_src1 == exe_dest);
    assign src2_hit       = id_src2_used & (id_src2 == exe_dest);
    assign load_use_stall = id_valid & exe_valid & exe_is_load
                          & (exe_dest != REG_AW'(REG_ZERO)) & (src1_hit | src2_hit);
    assign id_over_eff    = id_over & ~load_use_stall;

    // IF has no upstream stage: it refills from fetch_en.
    assign if_go       = if_valid & if_over & id_allow_in & ~flush;
    assign if_allow_in = ~if_valid | if_go;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if_valid <= 1'b0;
        end else if (flush) begin
            if_valid <= 1'b0;
        end else if (if_allow_in) begin
            if_valid <= fetch_en;
        end
    end

    pipe_stage_vld u_id (
        .clk(clk), .reset(reset), .prev_go(if_go), .over(id_over_eff),
        .next_allow_in(exe_allow_in), .flush(flush),
        .valid(id_valid), .allow_in(id_allow_in), .go(id_go)
    );

    pipe_stage_vld u_exe (
        .clk(clk), .reset(reset), .prev_go(id_go), .over(exe_over),
        .next_allow_in(mem_allow_in), .flush(flush),
        .valid(exe_valid), .allow_in(exe_allow_in), .go(exe_go)
    );

    pipe_stage_vld u_mem (
        .clk(clk), .reset(reset), .prev_go(exe_go), .over(mem_over),
        .next_allow_in(wb_allow_in), .flush(flush),
        .valid(mem_valid), .allow_in(mem_allow_in), .go(mem_go)
    );

    // WB retires in one cycle, so its own allow-in/go are not needed outside.
    pipe_stage_vld u_wb (
        .clk(clk), .reset(reset), .prev_go(mem_go), .over(1'b1),
        .next_allow_in(1'b1), .flush(flush),
        .valid(wb_valid), .allow_in(wb_allow_unused), .go(wb_go_unused)
    );

    always_comb begin
        stage_v          = '0;
        stage_v[STG_IF]  = if_valid;
        stage_v[STG_ID]  = id_valid;
        stage_v[STG_EXE] = exe_valid;
        stage_v[STG_MEM] = mem_valid;
        stage_v[STG_WB]  = wb_valid;
    end

    assign cpu_5_valid = DBG_W'(stage_v);

`ifdef PIPE_CTRL_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_retired <= '0;
            perf_stall   <= '0;
        end else begin
            if (wb_valid) begin
                perf_retired <= perf_retired + CNT_W'(1);
            end
            if (if_valid & ~if_go & ~flush) begin
                perf_stall <= perf_stall + CNT_W'(1);
            end
        end
    end
`else
    localparam int unsigned PERF_CNT_W_UNUSED = CNT_W;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with an instruction-order scoreboard.
`timescale 1ns/1ps
module tb_pipe_ctrl;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned CNT_W  = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              fetch_en;
    logic              if_over, id_over, exe_over, mem_over;
    logic [REG_AW-1:0] id_src1, id_src2, exe_dest;
    logic              id_src1_used, id_src2_used, exe_is_load, wb_flush;
    logic              if_valid, id_valid, exe_valid, mem_valid, wb_valid;
    logic              id_allow_in, exe_allow_in, mem_allow_in, wb_allow_in;
    logic              if_go, id_go, exe_go, mem_go;
    logic              load_use_stall;
    logic [31:0]       cpu_5_valid;
`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0]  perf_retired, perf_stall;
`endif

    pipe_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .fetch_en(fetch_en),
        .if_over(if_over), .id_over(id_over), .exe_over(exe_over), .mem_over(mem_over),
        .id_src1(id_src1), .id_src2(id_src2),
        .id_src1_used(id_src1_used), .id_src2_used(id_src2_used),
        .exe_dest(exe_dest), .exe_is_load(exe_is_load), .wb_flush(wb_flush),
        .if_valid(if_valid), .id_valid(id_valid), .exe_valid(exe_valid),
        .mem_valid(mem_valid), .wb_valid(wb_valid),
        .id_allow_in(id_allow_in), .exe_allow_in(exe_allow_in),
        .mem_allow_in(mem_allow_in), .wb_allow_in(wb_allow_in),
        .if_go(if_go), .id_go(id_go), .exe_go(exe_go), .mem_go(mem_go),
        .load_use_stall(load_use_stall), .cpu_5_valid(cpu_5_valid)
`ifdef PIPE_CTRL_PERF_EN
        , .perf_retired(perf_retired), .perf_stall(perf_stall)
`endif
    );

    always #5 clk = ~clk;

    int          n_pass   = 0;
    int          n_checks = 0;
    int unsigned exp_q[$];
    int unsigned next_id  = 1;
    int unsigned if_tag = 0, id_tag = 0, exe_tag = 0, mem_tag = 0, wb_tag = 0;
    int unsigned exp_retired = 0, exp_stall = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: tags move on go strobes, fetches are pushed, retirements popped.
    task automatic step();
        logic [4:0] v0;
        logic [3:0] g0;
        logic       fl0;
        int unsigned want;
        #1;
        v0  = {wb_valid, mem_valid, exe_valid, id_valid, if_valid};
        g0  = {mem_go, exe_go, id_go, if_go};
        fl0 = wb_valid & wb_flush;
        check("go_needs_valid", 32'(g0 & ~v0[3:0]), 32'd0);
        if (v0[4]) exp_retired++;
        if (v0[0] && !g0[0] && !fl0) exp_stall++;
        @(posedge clk);
        #1;
        if (fl0) begin
            exp_q.delete();
        end else begin
            if (g0[3]) wb_tag  = mem_tag;
            if (g0[2]) mem_tag = exe_tag;
            if (g0[1]) exe_tag = id_tag;
            if (g0[0]) id_tag  = if_tag;
            if (if_valid && (!v0[0] || g0[0])) begin
                if_tag = next_id;
                exp_q.push_back(next_id);
                next_id++;
            end
        end
        if (wb_valid) begin
            want = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
            check("retire_order", 32'(wb_tag), 32'(want));
        end
    endtask

    initial begin
        reset = 1'b1; fetch_en = 1'b0;
        if_over = 1'b1; id_over = 1'b1; exe_over = 1'b1; mem_over = 1'b1;
        id_src1 = '0; id_src2 = '0; exe_dest = '0;
        id_src1_used = 1'b0; id_src2_used = 1'b0; exe_is_load = 1'b0; wb_flush = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_valid", cpu_5_valid, 32'd0);
        check("reset_allow", 32'({id_allow_in, exe_allow_in, mem_allow_in, wb_allow_in}), 32'hF);
        check("reset_go", 32'({if_go, id_go, exe_go, mem_go, load_use_stall}), 32'd0);
`ifdef PIPE_CTRL_PERF_EN
        check("reset_perf", perf_retired | perf_stall, 32'd0);
`endif
        reset = 1'b0;
        step();
        check("no_fetch_disabled", cpu_5_valid, 32'd0);

        fetch_en = 1'b1;
        step(); check("fill_1", cpu_5_valid, 32'h01);
        step(); check("fill_2", cpu_5_valid, 32'h03);
        step(); check("fill_3", cpu_5_valid, 32'h07);
        step(); check("fill_4", cpu_5_valid, 32'h0F);
        step(); check("fill_5", cpu_5_valid, 32'h1F);
        repeat (3) step();
        check("stream_full", cpu_5_valid, 32'h1F);

        // Load-use: one bubble into EXE.
        exe_is_load = 1'b1; exe_dest = 5'd8; id_src1 = 5'd8; id_src1_used = 1'b1;
        #1;
        check("lu_stall_exego_idgo", 32'({load_use_stall, exe_go, id_go}), 32'b110);
        step();
        exe_is_load = 1'b0;
        #1;
        check("lu_bubble", cpu_5_valid, 32'h1B);
        check("lu_release", 32'({load_use_stall, id_go}), 32'b01);
        step(); check("lu_after_1", cpu_5_valid, 32'h17);
        step(); check("lu_after_2", cpu_5_valid, 32'h0F);
        step(); check("lu_after_3", cpu_5_valid, 32'h1F);

        // Non-hazard cases.
        exe_is_load = 1'b1; exe_dest = 5'd0; id_src1 = 5'd0; id_src1_used = 1'b1;
        #1; check("nostall_dest0", 32'(load_use_stall), 32'd0);
        exe_dest = 5'd8; id_src1 = 5'd8; id_src1_used = 1'b0;
        #1; check("nostall_unused", 32'(load_use_stall), 32'd0);
        id_src2 = 5'd8; id_src2_used = 1'b1;
        #1; check("stall_src2", 32'(load_use_stall), 32'd1);
        exe_is_load = 1'b0; id_src2_used = 1'b0;
        #1; check("nostall_notload", 32'(load_use_stall), 32'd0);
        step();

        // Backpressure: EXE busy for three cycles.
        exe_over = 1'b0;
        step(); check("bp_1", cpu_5_valid, 32'h17);
        step(); check("bp_2", cpu_5_valid, 32'h07);
        step(); check("bp_3", cpu_5_valid, 32'h07);
        check("bp_hold_go", 32'({if_go, id_go, exe_go}), 32'd0);
        exe_over = 1'b1;
        step(); check("bp_resume_1", cpu_5_valid, 32'h0F);
        step(); check("bp_resume_2", cpu_5_valid, 32'h1F);
        repeat (2) step();

        // Flush with a concurrent load-use hazard.
        wb_flush = 1'b1; exe_is_load = 1'b1; exe_dest = 5'd8; id_src1 = 5'd8; id_src1_used = 1'b1;
        #1;
        check("flush_stall_seen", 32'(load_use_stall), 32'd1);
        check("flush_go_forced", 32'({if_go, id_go, exe_go, mem_go}), 32'd0);
        step();
        wb_flush = 1'b0; exe_is_load = 1'b0;
        check("flush_clear", cpu_5_valid, 32'd0);
        step(); check("flush_refetch", cpu_5_valid, 32'h01);
        step(); step(); step();
        step(); check("flush_refill", cpu_5_valid, 32'h1F);
        repeat (2) step();
`ifdef PIPE_CTRL_PERF_EN
        check("perf_retired", perf_retired, 32'(exp_retired));
        check("perf_stall", perf_stall, 32'(exp_stall));
`endif

        // Asynchronous reset mid-cycle.
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_valid", cpu_5_valid, 32'd0);
        check("async_reset_go", 32'({if_go, id_go, exe_go, mem_go}), 32'd0);
`ifdef PIPE_CTRL_PERF_EN
        check("async_reset_perf", perf_retired | perf_stall, 32'd0);
`endif
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        exp_retired = 0; exp_stall = 0;
        step(); check("post_reset_fetch", cpu_5_valid, 32'h01);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central valid/allow-in sequencer for the five-stage pipeline CPU (IF, ID, EXE, MEM, WB). Owns every stage-valid bit and derives per-stage allow-in and go (transfer) strobes from stage-done signals. Also inserts load-use interlock bubbles and services the WB-initiated pipeline flush. The datapath stage registers latch only on this block's `*_go` strobes. The block also supplies the `cpu_5_valid` debug vector.

## Interface
- `REG_AW`, 5: register-file address width.
- `CNT_W`, 32: performance-counter width (used only with the counter feature).
- `clk`  in  1  pipeline clock.
- `reset`  in  1  asynchronous, active-high reset.
- `fetch_en`  in  1  enables issue of new fetches into IF.
- `if_over`, `id_over`, `exe_over`, `mem_over`  in  1 each  the stage's work for its current instruction is complete (for example, `exe_over` stays low while the multiplier runs).
- `id_src1`, `id_src2`  in  REG_AW  ID source register numbers.
- `id_src1_used`, `id_src2_used`  in  1  the corresponding source is read.
- `exe_dest`  in  REG_AW  EXE destination register (0 = none).
- `exe_is_load`  in  1  the EXE instruction is a load.
- `wb_flush`  in  1  the WB instruction requests a pipeline flush (exception or eret).
- `if_valid`, `id_valid`, `exe_valid`, `mem_valid`, `wb_valid`  out  1  stage-valid registers.
- `id_allow_in`, `exe_allow_in`, `mem_allow_in`, `wb_allow_in`  out  1  the stage can accept an instruction this cycle.
- `if_go`, `id_go`, `exe_go`, `mem_go`  out  1  transfer into the next stage at the coming edge.
- `load_use_stall`  out  1  the interlock is active this cycle.
- `cpu_5_valid`  out  32  bits [4:0] = {wb,mem,exe,id,if}_valid; bits [31:5] = 0.

## Operation
- Allow-in per stage: `allow_in_s = !valid_s | (go_s)`. `wb_allow_in` is always 1, because WB completes in one cycle.
- Go signals:
  - `go_s = valid_s & over_eff_s & allow_in_{s+1}`.
  - `over_eff_id = id_over & !load_use_stall`.
  - For all other stages, `over_eff = over`.
- Load-use interlock: `load_use_stall = id_valid & exe_valid & exe_is_load & exe_dest!=0 & ((id_src1_used & id_src1==exe_dest) | (id_src2_used & id_src2==exe_dest))`. Only EXE loads trigger it; MEM and WB results are covered by forwarding.
- Stage-valid update at each edge:
  - If `allow_in_{s+1}`, then `valid_{s+1} <= go_s`; otherwise it holds. The same rule applies to WB (`valid_wb <= go_mem`).
  - IF: `if_valid <= fetch_en` when IF allow-in is true; otherwise it holds.
- Flush: `flush = wb_valid & wb_flush`.
  - At the next edge, if/id/exe/mem valid all clear and `wb_valid <= 0`.
  - IF refetches on the following edge if `fetch_en` is set.
  - Flush overrides any concurrent go or stall.
  - All `*_go` outputs are forced to 0 during the flush cycle.
- A stage that is not valid never asserts go, regardless of its `over` input.

## Timing
- Reset: all `*_valid` = 0, `load_use_stall` = 0, `cpu_5_valid` = 0, every `*_go` = 0, every `*_allow_in` = 1, counters = 0.
- First fetch: `if_valid` rises on the first edge after reset deasserts with `fetch_en` = 1.
- Unstalled latency: an instruction valid in IF at cycle n is valid in WB at cycle n+4.
- Sustained throughput: 1 instruction per cycle when all `over` inputs are high.
- Load-use: exactly one bubble. Cycle n: stall and EXE go. Cycle n+1: `exe_valid` = 0, the load is in MEM, the stall drops, ID goes.
- Backpressure: `exe_over` low for k cycles holds EXE, ID and IF for k cycles. MEM receives bubbles (`mem_valid` = 0) during that time.
- Reset mid-operation clears all valids asynchronously. In-flight instructions are discarded without any go strobe.

## Configuration
- `PIPE_CTRL_PERF_EN`: when defined, adds outputs `perf_retired` [CNT_W] and `perf_stall` [CNT_W].
  - `perf_retired` increments on each cycle with `wb_valid`.
  - `perf_stall` increments on each cycle where IF holds, i.e. `if_valid & !if_go & !flush`.
  - Both counters wrap modulo 2^CNT_W and reset to 0.
- When not defined, these ports and registers do not exist.

## Structure
- Package `pipe_pkg` holds the shared constants:
  - `STAGE_NUM` = 5.
  - Stage index constants `STG_IF`..`STG_WB` (0..4), used for `cpu_5_valid` bit positions.
  - `REG_ZERO` = 0.
- Sub-module `pipe_stage_vld` is one valid/allow-in/go cell, instantiated four times (ID..WB). Its ports are `prev_go`, `over`, `next_allow_in`, `flush`, `valid`, `allow_in` and `go`. IF uses dedicated logic.

## Test plan
- Reset with `fetch_en` = 0 → all valids 0, all allow-ins 1, `cpu_5_valid` = 0. After setting `fetch_en` = 1 → `if_valid` = 1 one edge later.
- Stream with all `over` inputs = 1 → `cpu_5_valid[4:0]` goes 00001, 00011, 00111, 01111, 11111 on successive edges.
- Load-use: `exe_is_load` = 1, `exe_dest` = 8, `id_src1` = 8, `id_src1_used` = 1 → `load_use_stall` = 1 for exactly one cycle, `exe_valid` = 0 on the next cycle, then ID proceeds.
- Same register pair but `exe_dest` = 0, or `id_src1_used` = 0 → no stall.
- `exe_over` held low for 3 cycles with a full pipe → IF/ID/EXE hold, `mem_valid` = 0 for 3 cycles, then the pipe resumes with no instruction lost or duplicated.
- `wb_flush` = 1 with a full pipe and a simultaneous load-use stall → the next edge gives `cpu_5_valid` = 0, then `if_valid` = 1 one edge later. With `PIPE_CTRL_PERF_EN`, `perf_retired` counts only instructions that reached WB.
